score_accumulator: RTL and testbench



---
 rtl/score_pkg.sv | 47 ++++
 rtl/score_accumulator_if.sv | 29 ++
 rtl/score_accumulator_grade_classifier.sv | 19 +
 rtl/score_accumulator.sv | 80 ++++++++
 tb/tb_score_accumulator.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared grade encoding, default windows/points, score-state widths and types
// Used by score_accumulator, grade_classifier and the HUD renderer.
package score_pkg;
  localparam int DT_W = 16;
  localparam int SCORE_W = 24;
  localparam int COMBO_W = 10;
  localparam int TALLY_W = 12;
  localparam int MULT_W = 3;
  localparam int DEF_PERFECT_WIN = 20;
  localparam int DEF_GOOD_WIN = 50;
  localparam int DEF_OK_WIN = 100;
  localparam int DEF_PTS_PERFECT = 100;
  localparam int DEF_PTS_GOOD = 50;
  localparam int DEF_PTS_OK = 20;
  localparam int DEF_COMBO_STEP = 10;
  localparam int DEF_MULT_MAX = 4;
  typedef enum logic [1:0] {
    GRADE_MISS = 2'd0,
    GRADE_OK = 2'd1,
    GRADE_GOOD = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_t;
  typedef struct packed {
    logic valid;
    grade_t grade;
    logic miss;
  } s1_t;
  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic [MULT_W-1:0] mult;
    grade_t grade;
    logic grade_valid;
    logic [TALLY_W-1:0] cnt_perfect;
    logic [TALLY_W-1:0] cnt_good;
    logic [TALLY_W-1:0] cnt_ok;
    logic [TALLY_W-1:0] cnt_miss;
  } acc_t;
  localparam acc_t ACC_RST = '{mult: MULT_W'(1), grade: GRADE_MISS, default: '0};
  // add 0..3 to a tally, holding at all-ones instead of wrapping
  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v, input logic [1:0] n);
    logic [TALLY_W:0] s;
    s = {1'b0, v} + (TALLY_W+1)'(n);
    return s[TALLY_W] ? '1 : s[TALLY_W-1:0];
  endfunction
endpackage

// File: rtl/score_accumulator_if.sv
// score_accumulator_if: match/miss event inputs and score/HUD outputs of the accumulator
// master: event source + HUD reader; slave: score_accumulator.
interface score_accumulator_if;
  import score_pkg::*;
  logic match_en;
  logic signed [DT_W-1:0] match_dt;
  logic miss_en;
  logic song_clear;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;
  logic [MULT_W-1:0] multiplier;
  grade_t grade;
  logic grade_valid;
  logic [TALLY_W-1:0] cnt_perfect;
  logic [TALLY_W-1:0] cnt_good;
  logic [TALLY_W-1:0] cnt_ok;
  logic [TALLY_W-1:0] cnt_miss;
  modport master (
    output match_en, match_dt, miss_en, song_clear,
    input score, combo, max_combo, multiplier, grade, grade_valid,
    input cnt_perfect, cnt_good, cnt_ok, cnt_miss
  );
  modport slave (
    input match_en, match_dt, miss_en, song_clear,
    output score, combo, max_combo, multiplier, grade, grade_valid,
    output cnt_perfect, cnt_good, cnt_ok, cnt_miss
  );
endinterface

// File: rtl/score_accumulator_grade_classifier.sv
// grade_classifier: combinational |dt| window compare giving a grade
// dt: signed timing error; grade: PERFECT/GOOD/OK/MISS with inclusive bounds.
module grade_classifier
  import score_pkg::*;
#(
  parameter int PERFECT_WIN = DEF_PERFECT_WIN,
  parameter int GOOD_WIN = DEF_GOOD_WIN,
  parameter int OK_WIN = DEF_OK_WIN
) (
  input logic signed [DT_W-1:0] dt,
  output grade_t grade
);
  logic [DT_W-1:0] mag;
  // the most negative input has no positive twin, so it clamps to the largest magnitude
  assign mag = dt == {1'b1, {(DT_W-1){1'b0}}} ? {1'b0, {(DT_W-1){1'b1}}} : dt[DT_W-1] ? -dt : dt;
  assign grade = mag <= DT_W'(PERFECT_WIN) ? GRADE_PERFECT :
                 mag <= DT_W'(GOOD_WIN) ? GRADE_GOOD :
                 mag <= DT_W'(OK_WIN) ? GRADE_OK : GRADE_MISS;
endmodule

// File: rtl/score_accumulator.sv
// score_accumulator: grades match events, tracks combo/multiplier, running score and tallies
// clk, rst_n (async active-low); bus (slave): match_en/match_dt/miss_en/song_clear in,
// score/combo/max_combo/multiplier/grade/grade_valid/cnt_* out. Events show up two edges later.
module score_accumulator
  import score_pkg::*;
#(
  parameter int PERFECT_WIN = DEF_PERFECT_WIN,
  parameter int GOOD_WIN = DEF_GOOD_WIN,
  parameter int OK_WIN = DEF_OK_WIN,
  parameter int PTS_PERFECT = DEF_PTS_PERFECT,
  parameter int PTS_GOOD = DEF_PTS_GOOD,
  parameter int PTS_OK = DEF_PTS_OK,
  parameter int COMBO_STEP = DEF_COMBO_STEP,
  parameter int MULT_MAX = DEF_MULT_MAX
) (
  input logic clk,
  input logic rst_n,
  score_accumulator_if.slave bus
);
  grade_t c_grade;
  s1_t s1, s1_d;
  acc_t q, d;
  logic hit, dt_miss;
  logic [1:0] n_miss;
  logic [15:0] base;
  logic [18:0] pts;
  logic [SCORE_W:0] sum;
  logic [COMBO_W-1:0] combo_hit, step;
  logic [MULT_W-1:0] mult_hit;
  grade_classifier #(.PERFECT_WIN(PERFECT_WIN), .GOOD_WIN(GOOD_WIN), .OK_WIN(OK_WIN)) u_cls (
    .dt(bus.match_dt),
    .grade(c_grade)
  );
  always_comb begin
    hit = s1.valid && s1.grade != GRADE_MISS;
    dt_miss = s1.valid && s1.grade == GRADE_MISS;
    n_miss = {1'b0, dt_miss} + {1'b0, s1.miss};
    base = s1.grade == GRADE_PERFECT ? 16'(PTS_PERFECT) : s1.grade == GRADE_GOOD ? 16'(PTS_GOOD) : 16'(PTS_OK);
    pts = 19'(base) * 19'(q.mult);
    sum = (SCORE_W+1)'(q.score) + (SCORE_W+1)'(pts);
    combo_hit = &q.combo ? q.combo : q.combo + 1'b1;
    step = combo_hit / COMBO_W'(COMBO_STEP);
    mult_hit = step >= COMBO_W'(MULT_MAX - 1) ? MULT_W'(MULT_MAX) : MULT_W'(step) + 1'b1;
    s1_d = '{valid: bus.match_en, grade: c_grade, miss: bus.miss_en};
    d = q;
    d.grade_valid = s1.valid | s1.miss;
    d.grade = s1.valid ? s1.grade : s1.miss ? GRADE_MISS : q.grade;
    d.score = !hit ? q.score : sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    d.max_combo = hit && combo_hit > q.max_combo ? combo_hit : q.max_combo;
    // a coincident miss lands after the hit, so it wins for combo and multiplier
    d.combo = n_miss != 2'd0 ? '0 : hit ? combo_hit : q.combo;
    d.mult = n_miss != 2'd0 ? MULT_W'(1) : hit ? mult_hit : q.mult;
    d.cnt_perfect = sat_inc(q.cnt_perfect, {1'b0, hit && s1.grade == GRADE_PERFECT});
    d.cnt_good = sat_inc(q.cnt_good, {1'b0, hit && s1.grade == GRADE_GOOD});
    d.cnt_ok = sat_inc(q.cnt_ok, {1'b0, hit && s1.grade == GRADE_OK});
    d.cnt_miss = sat_inc(q.cnt_miss, n_miss);
    if (bus.song_clear) begin
      d = ACC_RST;
      s1_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= ACC_RST;
      s1 <= '0;
    end else begin
      q <= d;
      s1 <= s1_d;
    end
  assign bus.score = q.score;
  assign bus.combo = q.combo;
  assign bus.max_combo = q.max_combo;
  assign bus.multiplier = q.mult;
  assign bus.grade = q.grade;
  assign bus.grade_valid = q.grade_valid;
  assign bus.cnt_perfect = q.cnt_perfect;
  assign bus.cnt_good = q.cnt_good;
  assign bus.cnt_ok = q.cnt_ok;
  assign bus.cnt_miss = q.cnt_miss;
endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator: directed stimulus with a behavioural scoring model checked every cycle
module tb_score_accumulator;
  import score_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit chk_on = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  score_accumulator_if bus();
  score_accumulator dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {bit hit; int g; bit miss;} ev_t;
  ev_t pend[$];
  int m_score, m_combo, m_max, m_mult, m_grade, m_gv;
  int m_cnt[4];
  function automatic int classify(input logic [15:0] dt);
    int a;
    a = int'($signed(dt));
    if (a < 0) a = -a;
    if (a > 32767) a = 32767;
    return a <= 20 ? 3 : a <= 50 ? 2 : a <= 100 ? 1 : 0;
  endfunction
  function automatic void m_reset();
    m_score = 0; m_combo = 0; m_max = 0; m_mult = 1; m_grade = 0; m_gv = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    pend.delete();
  endfunction
  function automatic void m_apply(input ev_t e);
    int pts[4] = '{0, 20, 50, 100};
    int misses;
    misses = e.miss ? 1 : 0;
    if (e.hit && e.g != 0) begin
      m_score = m_score + pts[e.g] * m_mult;
      if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
      if (m_combo < 1023) m_combo++;
      m_mult = 1 + m_combo / 10;
      if (m_mult > 4) m_mult = 4;
      if (m_combo > m_max) m_max = m_combo;
      if (m_cnt[e.g] < 4095) m_cnt[e.g]++;
    end
    if (e.hit && e.g == 0) misses++;
    if (misses > 0) begin
      m_combo = 0;
      m_mult = 1;
      m_cnt[0] = m_cnt[0] + misses > 4095 ? 4095 : m_cnt[0] + misses;
    end
    m_grade = e.hit ? e.g : 0;
    m_gv = 1;
  endfunction
  function automatic void chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endfunction
  task automatic step(input bit me, input int dt, input bit mi, input bit sc);
    ev_t e;
    bus.match_en = me;
    bus.match_dt = 16'(dt);
    bus.miss_en = mi;
    bus.song_clear = sc;
    @(posedge clk);
    m_gv = 0;
    if (sc) m_reset();
    else begin
      if (pend.size() > 0) begin
        e = pend.pop_front();
        if (e.hit || e.miss) m_apply(e);
      end
      e.hit = me; e.g = classify(16'(dt)); e.miss = mi;
      pend.push_back(e);
    end
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("score", int'(bus.score), m_score);
      chk("combo", int'(bus.combo), m_combo);
      chk("max_combo", int'(bus.max_combo), m_max);
      chk("multiplier", int'(bus.multiplier), m_mult);
      chk("grade_valid", int'(bus.grade_valid), m_gv);
      chk("grade", int'(bus.grade), m_grade);
      chk("cnt_perfect", int'(bus.cnt_perfect), m_cnt[3]);
      chk("cnt_good", int'(bus.cnt_good), m_cnt[2]);
      chk("cnt_ok", int'(bus.cnt_ok), m_cnt[1]);
      chk("cnt_miss", int'(bus.cnt_miss), m_cnt[0]);
    end
  end
  int dts[6] = '{-20, 21, -50, 100, 101, -32768};
  int egr[6] = '{3, 2, 2, 1, 0, 0};
  int esc[6] = '{200, 250, 300, 320, 320, 320};
  initial begin
    bus.match_en = 0; bus.match_dt = '0; bus.miss_en = 0; bus.song_clear = 0;
    #2 rst_n = 1'b0;
    m_reset();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_multiplier", int'(bus.multiplier), 1);
    chk("rst_score", int'(bus.score), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 1: single PERFECT
    step(1, 5, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_grade", int'(bus.grade), 3);
    chk("t1_valid", int'(bus.grade_valid), 1);
    chk("t1_score", int'(bus.score), 100);
    chk("t1_combo", int'(bus.combo), 1);
    chk("t1_mult", int'(bus.multiplier), 1);
    chk("t1_cnt_perfect", int'(bus.cnt_perfect), 1);
    // 2: window boundaries, each after a miss
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0);
      step(1, dts[i], 0, 0);
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("t2_grade", int'(bus.grade), egr[i]);
      chk("t2_score", int'(bus.score), esc[i]);
      chk("t2_combo", int'(bus.combo), egr[i] > 0 ? 1 : 0);
    end
    // 3: back-to-back hits and multiplier steps
    step(0, 0, 0, 1);
    repeat (10) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_score10", int'(bus.score), 1000);
    chk("t3_mult10", int'(bus.multiplier), 2);
    chk("t3_combo10", int'(bus.combo), 10);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_score11", int'(bus.score), 1200);
    repeat (29) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_mult40", int'(bus.multiplier), 4);
    repeat (20) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_mult60", int'(bus.multiplier), 4);
    chk("t3_combo60", int'(bus.combo), 60);
    chk("t3_score60", int'(bus.score), 18000);
    // 4: hit and miss_en together at combo 9
    step(0, 0, 0, 1);
    repeat (9) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_score", int'(bus.score), 1000);
    chk("t4_cnt_perfect", int'(bus.cnt_perfect), 10);
    chk("t4_cnt_miss", int'(bus.cnt_miss), 1);
    chk("t4_combo", int'(bus.combo), 0);
    chk("t4_max_combo", int'(bus.max_combo), 10);
    chk("t4_mult", int'(bus.multiplier), 1);
    chk("t4_grade", int'(bus.grade), 3);
    chk("t4_valid", int'(bus.grade_valid), 1);
    step(1, 200, 1, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_valid_pulse", int'(bus.grade_valid), 1);
    chk("t4_double_miss", int'(bus.cnt_miss), 3);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_valid_drop", int'(bus.grade_valid), 0);
    // 5: score and tally saturation
    step(0, 0, 0, 1);
    repeat (41958) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_preload", int'(bus.score), 32'hFFFFF0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_score_sat", int'(bus.score), 32'hFFFFFF);
    chk("t5_combo_sat", int'(bus.combo), 1023);
    chk("t5_perfect_sat", int'(bus.cnt_perfect), 4095);
    repeat (4100) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_miss_sat", int'(bus.cnt_miss), 4095);
    // 6: song_clear with events in flight, then async reset mid-stream
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("t6_clear_valid", int'(bus.grade_valid), 0);
    end
    chk("t6_clear_score", int'(bus.score), 0);
    chk("t6_clear_mult", int'(bus.multiplier), 1);
    chk("t6_clear_miss", int'(bus.cnt_miss), 0);
    repeat (3) step(1, 30, 0, 0);
    bus.match_en = 1;
    #2 rst_n = 1'b0;
    m_reset();
    bus.match_en = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("t6_rst_valid", int'(bus.grade_valid), 0);
    end
    chk("t6_rst_score", int'(bus.score), 0);
    chk("t6_rst_good", int'(bus.cnt_good), 0);
    chk("t6_rst_combo", int'(bus.combo), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
